// File: rtl/reservoir_emulator.sv
// Tank-and-field plant model: integrates tank level and soil moisture once per
// emulation step and drives the level/soil/climate sensors. Optional fault injection via RESERVOIR_FAULT_EN.
module reservoir_emulator #(
  parameter int STEP_DIV   = 50_000_000,
  parameter int LEVEL_MAX  = 100,
  parameter int INIT_LEVEL = 0,
  parameter int L_TH       = 10,
  parameter int M_TH       = 50,
  parameter int H_TH       = 90,
  parameter int SOIL_MAX   = 100,
  parameter int US_TH      = 60,
  parameter int DAY_STEPS  = 24
) (
  input  logic       clk,
  input  logic       reiniciar,
  input  logic       Ve,
  input  logic       Vs,
  input  logic       Bs,
  input  logic       pause,
`ifdef RESERVOIR_FAULT_EN
  input  logic       fault_inject,
`endif
  output logic       H,
  output logic       M,
  output logic       L,
  output logic       Us,
  output logic       Ua,
  output logic       T,
  output logic [6:0] level,
  output logic [6:0] soil,
  output logic       step
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DAY_W = $clog2(DAY_STEPS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DAY_W-1:0] DAY_LAST = DAY_W'(DAY_STEPS - 1);
  localparam logic [DAY_W-1:0] DAY_HALF = DAY_W'(DAY_STEPS / 2);
  localparam logic [6:0] LVL_INIT7 = 7'(INIT_LEVEL);
  localparam logic [6:0] LVL_MAX7  = 7'(LEVEL_MAX);
  localparam logic [6:0] SOIL_MAX7 = 7'(SOIL_MAX);
  localparam logic [6:0] L_TH7     = 7'(L_TH);
  localparam logic [6:0] M_TH7     = 7'(M_TH);
  localparam logic [6:0] H_TH7     = 7'(H_TH);
  localparam logic [6:0] US_TH7    = 7'(US_TH);
  localparam logic signed [8:0] LVL_MAX_S  = 9'(LEVEL_MAX);
  localparam logic signed [8:0] SOIL_MAX_S = 9'(SOIL_MAX);

  logic [DIV_W-1:0] r_div;
  logic [DAY_W-1:0] r_day;
  logic [6:0]       r_level;
  logic [6:0]       r_soil;
  logic             r_h, r_m, r_l, r_us, r_ua, r_t;

  logic             w_step;
  logic             w_fault;
  logic signed [8:0] w_level_sum;
  logic signed [8:0] w_water;
  logic signed [8:0] w_soil_sum;
  logic [6:0]       w_level_sat;
  logic [6:0]       w_soil_sat;
  logic [6:0]       w_level_post;
  logic [6:0]       w_soil_post;
  logic [DAY_W-1:0] w_day_inc;
  logic [DAY_W-1:0] w_day_post;

`ifdef RESERVOIR_FAULT_EN
  assign w_fault = fault_inject;
`else
  assign w_fault = 1'b0;
`endif

  assign w_step = (r_div == DIV_LAST) && !pause;

  // All arithmetic is on pre-step values; an empty tank cannot deliver water.
  always_comb begin
    w_level_sum = $signed({2'b00, r_level})
                + (Ve ? 9'sd3 : 9'sd0)
                - (Vs ? 9'sd2 : 9'sd0)
                - (Bs ? 9'sd1 : 9'sd0);
    w_water     = (r_level != 7'd0) ? $signed({7'b0000000, Vs, Bs}) : 9'sd0;
    w_soil_sum  = $signed({2'b00, r_soil}) + w_water - (r_t ? 9'sd2 : 9'sd1);

    if (w_level_sum < 9'sd0) begin
      w_level_sat = 7'd0;
    end else if (w_level_sum > LVL_MAX_S) begin
      w_level_sat = LVL_MAX7;
    end else begin
      w_level_sat = w_level_sum[6:0];
    end

    if (w_soil_sum < 9'sd0) begin
      w_soil_sat = 7'd0;
    end else if (w_soil_sum > SOIL_MAX_S) begin
      w_soil_sat = SOIL_MAX7;
    end else begin
      w_soil_sat = w_soil_sum[6:0];
    end

    w_day_inc    = (r_day == DAY_LAST) ? '0 : r_day + 1'b1;
    w_level_post = w_step ? w_level_sat : r_level;
    w_soil_post  = w_step ? w_soil_sat  : r_soil;
    w_day_post   = w_step ? w_day_inc   : r_day;
  end

  // Sensors are re-registered every cycle from post-step values, so they hold between steps.
  always_ff @(posedge clk) begin
    if (reiniciar) begin
      r_div   <= '0;
      r_day   <= '0;
      r_level <= LVL_INIT7;
      r_soil  <= 7'd0;
      r_h     <= (LVL_INIT7 >= H_TH7);
      r_m     <= (LVL_INIT7 >= M_TH7);
      r_l     <= (LVL_INIT7 >= L_TH7);
      r_us    <= (7'd0 >= US_TH7);
      r_t     <= 1'b0;
      r_ua    <= 1'b1;
    end else begin
      if (!pause) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
      r_level <= w_level_post;
      r_soil  <= w_soil_post;
      r_day   <= w_day_post;
      r_h     <= w_fault | (w_level_post >= H_TH7);
      r_m     <= !w_fault & (w_level_post >= M_TH7);
      r_l     <= !w_fault & (w_level_post >= L_TH7);
      r_us    <= (w_soil_post >= US_TH7);
      r_t     <= (w_day_post >= DAY_HALF);
      r_ua    <= !(w_day_post >= DAY_HALF);
    end
  end

  assign H     = r_h;
  assign M     = r_m;
  assign L     = r_l;
  assign Us    = r_us;
  assign Ua    = r_ua;
  assign T     = r_t;
  assign level = r_level;
  assign soil  = r_soil;
  assign step  = w_step;

endmodule

// File: tb/tb_reservoir_emulator.sv
// Self-checking bench for reservoir_emulator: phase table plus a per-step
// scoreboard fed by a reference model, and hand sequences for pause/reset/fault.
module tb_reservoir_emulator;
  localparam int SD = 4;
  localparam int DS = 4;

  logic clk = 1'b0;
  logic reiniciar, Ve, Vs, Bs, pause;
  logic H, M, L, Us, Ua, T, step;
  logic [6:0] level, soil;
`ifdef RESERVOIR_FAULT_EN
  logic fault_inject;
`endif

  reservoir_emulator #(.STEP_DIV(SD), .DAY_STEPS(DS)) dut (
    .clk(clk), .reiniciar(reiniciar), .Ve(Ve), .Vs(Vs), .Bs(Bs), .pause(pause),
`ifdef RESERVOIR_FAULT_EN
    .fault_inject(fault_inject),
`endif
    .H(H), .M(M), .L(L), .Us(Us), .Ua(Ua), .T(T),
    .level(level), .soil(soil), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ve, vs, bs;
    int   nsteps;
    int   exp_level;
  } phase_t;

  typedef struct {
    int   level, soil;
    logic h, m, l, us, ua, t;
    int   idx;
  } exp_t;

  phase_t tbl[6];
  exp_t   sb[$];
  int vectors = 0;
  int miscompares = 0;
  int m_level, m_soil, m_day;
  logic m_t;
  int step_no = 0;

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_soil = 0; m_day = 0; m_t = 1'b0;
  endtask

  // Wait (bounded) for a step cycle, scrambling valves meanwhile: they must be ignored.
  task automatic wait_step(output logic ok);
    ok = 1'b0;
    if (step === 1'b1) begin
      ok = 1'b1;
      return;
    end
    for (int n = 0; n < 4 * SD; n++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        ok = 1'b1;
        break;
      end
      Ve = 1'($urandom_range(0, 1));
      Vs = 1'($urandom_range(0, 1));
      Bs = 1'($urandom_range(0, 1));
    end
    if (!ok) check("step_timeout", 0, 1);
  endtask

  // Called during a step cycle: drive valves, push model expectation, compare after the edge.
  task automatic apply_step(input logic ve, input logic vs, input logic bs);
    exp_t e, g;
    int ive, ivs, ibs, water, evap, soil_before, lvl_before;
    ive = int'(ve); ivs = int'(vs); ibs = int'(bs);
    Ve = ve; Vs = vs; Bs = bs;
    lvl_before  = m_level;
    soil_before = int'(soil);
    water   = (m_level > 0) ? 2 * ivs + ibs : 0;
    evap    = m_t ? 2 : 1;
    m_level = clamp(m_level + 3 * ive - 2 * ivs - ibs, 100);
    m_soil  = clamp(m_soil + water - evap, 100);
    m_day   = (m_day + 1) % DS;
    m_t     = (m_day >= DS / 2);
    step_no++;
    e.level = m_level; e.soil = m_soil;
    e.h = (m_level >= 90); e.m = (m_level >= 50); e.l = (m_level >= 10);
    e.us = (m_soil >= 60); e.t = m_t; e.ua = !m_t; e.idx = step_no;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    vectors++;
    if (int'(level) != g.level || int'(soil) != g.soil ||
        {H, M, L, Us, Ua, T} != {g.h, g.m, g.l, g.us, g.ua, g.t}) begin
      miscompares++;
      $display("FAIL step %0d: got level=%0d soil=%0d HMLUsUaT=%b, required level=%0d soil=%0d HMLUsUaT=%b",
               g.idx, level, soil, {H, M, L, Us, Ua, T}, g.level, g.soil,
               {g.h, g.m, g.l, g.us, g.ua, g.t});
    end else begin
      $display("step %0d valves=%b%b%b level=%0d soil=%0d HMLUsUaT=%b ok",
               g.idx, ve, vs, bs, level, soil, {H, M, L, Us, Ua, T});
    end
    if (lvl_before == 0) check("soil_no_rise_empty_tank", int'(soil <= 7'(soil_before)), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    int l_rise, m_rise, h_rise;
    logic [11:0] snap;

    tbl[0] = '{ve: 1'b1, vs: 1'b0, bs: 1'b0, nsteps: 36, exp_level: 100};
    tbl[1] = '{ve: 1'b0, vs: 1'b1, bs: 1'b1, nsteps: 40, exp_level: 0};
    tbl[2] = '{ve: 1'b1, vs: 1'b0, bs: 1'b0, nsteps: 17, exp_level: 51};
    tbl[3] = '{ve: 1'b0, vs: 1'b0, bs: 1'b1, nsteps: 1,  exp_level: 50};
    tbl[4] = '{ve: 1'b1, vs: 1'b1, bs: 1'b1, nsteps: 12, exp_level: 50};
    tbl[5] = '{ve: 1'b1, vs: 1'b0, bs: 1'b0, nsteps: 15, exp_level: 95};

    reiniciar = 1'b1; pause = 1'b0; Ve = 1'b0; Vs = 1'b0; Bs = 1'b0;
`ifdef RESERVOIR_FAULT_EN
    fault_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_level", int'(level), 0);
    check("reset_soil", int'(soil), 0);
    check("reset_HMLUsT", int'({H, M, L, Us, T}), 0);
    check("reset_Ua", int'(Ua), 1);
    check("reset_step", int'(step), 0);
    reiniciar = 1'b0;
    model_reset();

    // First step pulse appears in the STEP_DIV-th cycle after reset.
    @(negedge clk); check("first_step_c1", int'(step), 0);
    @(negedge clk); check("first_step_c2", int'(step), 0);
    @(negedge clk); check("first_step_c3", int'(step), 1);

    l_rise = 0; m_rise = 0; h_rise = 0;
    for (int p = 0; p < 6; p++) begin
      for (int s = 0; s < tbl[p].nsteps; s++) begin
        wait_step(ok);
        if (!ok) break;
        apply_step(tbl[p].ve, tbl[p].vs, tbl[p].bs);
        if (p == 0) begin
          if (L && l_rise == 0) l_rise = s + 1;
          if (M && m_rise == 0) m_rise = s + 1;
          if (H && h_rise == 0) h_rise = s + 1;
          if (s < 8) check("day_T_pattern", int'(T), int'(((s + 1) % 4) >= 2));
        end
      end
      check("phase_end_level", int'(level), tbl[p].exp_level);
    end
    check("L_rise_step", l_rise, 4);
    check("M_rise_step", m_rise, 17);
    check("H_rise_step", h_rise, 30);

    // Pause during a step cycle: nothing moves; releasing fires the step at once.
    wait_step(ok);
    pause = 1'b1;
    #1;
    check("pause_kills_step", int'(step), 0);
    snap = {level, soil[4:0]};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("pause_hold", int'({level, soil[4:0], step, H, M, L, Ua}),
            int'({snap, 1'b0, 1'b1, 1'b1, 1'b1, !m_t}));
    end
    pause = 1'b0;
    #1;
    check("step_after_release", int'(step), 1);
    apply_step(1'b0, 1'b0, 1'b0);
    wait_step(ok);
    if (ok) apply_step(1'b0, 1'b0, 1'b0);

`ifdef RESERVOIR_FAULT_EN
    @(negedge clk);
    fault_inject = 1'b1;
    @(negedge clk);
    check("fault_HML", int'({H, M, L}), 4);
    fault_inject = 1'b0;
    @(negedge clk);
    check("fault_recover_HML", int'({H, M, L}), 7);
    check("fault_level_kept", int'(level), m_level);
`endif

    // Reach T=1, then reset during a step cycle: step discarded, Ua back to 1.
    for (int k = 0; k < DS && !m_t; k++) begin
      wait_step(ok);
      if (ok) apply_step(1'b0, 1'b0, 1'b0);
    end
    check("pre_reset_T", int'(T), 1);
    wait_step(ok);
    Ve = 1'b1;
    reiniciar = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_reset_level", int'(level), 0);
    check("midrun_reset_Ua", int'(Ua), 1);
    check("midrun_reset_soil", int'(soil), 0);
    @(negedge clk);
    reiniciar = 1'b0;
    model_reset();
    wait_step(ok);
    if (ok) apply_step(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
